zad1_rx_decoder: RTL and testbench

Serial receiver and decoder for the 6-bit one-of/two-of-zero codeword produced by the `zad1` 3→6 encoder. It deframes a start/data/stop serial stream sampled on an external bit strobe, checks the received word against the eight legal codewords, and returns the original 3-bit value. Frame and code violations are flagged and counted. It sits at the far end of the link that carries `zad1` outputs, next to the baud/strobe generator.

---
 rtl/zad1_rx_decoder.sv | 110 +++++++++++
 tb/tb_zad1_rx_decoder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zad1_rx_decoder.sv
// Serial receiver for zad1 6-bit codewords: deframes start/data/stop on bit_en
// strobes, decodes the word back to a 3-bit value and counts frame/code errors.
module zad1_rx_decoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_en,
    input  logic                 ser_in,
    input  logic                 err_clr,
    output logic [2:0]           x_out,
    output logic                 x_valid,
    output logic                 code_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, DATA, STOP, WAIT_IDLE} state_t;

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic [5:0] word, word_nxt;
    logic       legal;
    logic [2:0] dec;
    logic       valid_nxt, code_nxt, frame_nxt, err_evt;

    always_comb begin
        legal = 1'b1;
        dec   = '0;
        case (word)
            6'h3E:   dec = 3'd0;
            6'h3D:   dec = 3'd1;
            6'h3B:   dec = 3'd2;
            6'h37:   dec = 3'd3;
            6'h2F:   dec = 3'd4;
            6'h1F:   dec = 3'd5;
            6'h2B:   dec = 3'd6;
            6'h17:   dec = 3'd7;
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            word  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            word  <= word_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        word_nxt  = word;
        if (bit_en) begin
            case (state)
                IDLE: begin
                    if (!ser_in) begin
                        state_nxt = DATA;
                        cnt_nxt   = '0;
                    end
                end
                DATA: begin
                    // LSB first: after six shifts y[0] sits in bit 0
                    word_nxt = {ser_in, word[5:1]};
                    cnt_nxt  = cnt + 3'd1;
                    if (cnt == 3'd5) state_nxt = STOP;
                end
                STOP:      state_nxt = ser_in ? IDLE : WAIT_IDLE;
                WAIT_IDLE: if (ser_in) state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        valid_nxt = bit_en && (state == STOP) && ser_in && legal;
        code_nxt  = bit_en && (state == STOP) && ser_in && !legal;
        frame_nxt = bit_en && (state == STOP) && !ser_in;
        err_evt   = code_nxt || frame_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_out     <= '0;
            x_valid   <= 1'b0;
            code_err  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            err_cnt   <= '0;
        end else begin
            x_valid   <= valid_nxt;
            code_err  <= code_nxt;
            frame_err <= frame_nxt;
            busy      <= (state_nxt != IDLE);
            if (valid_nxt) x_out <= dec;
            // a clear coinciding with an error leaves that one error counted
            if (err_clr)
                err_cnt <= ERR_CNT_W'(err_evt);
            else if (err_evt && (err_cnt != '1))
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_zad1_rx_decoder.sv
// Scoreboard bench for zad1_rx_decoder: one 8-bit-counter DUT and one
// 2-bit-counter DUT share the same serial stimulus.
module tb_zad1_rx_decoder;

    localparam int K_VALID = 0;
    localparam int K_CODE  = 1;
    localparam int K_FRAME = 2;

    typedef struct packed {
        logic [1:0] kind;
        logic [2:0] x;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n, bit_en, ser_in, err_clr;
    logic [2:0] x_out, x_out2;
    logic       x_valid, code_err, frame_err, busy;
    logic       x_valid2, code_err2, frame_err2, busy2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;

    ev_t        sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         valid_seen = 0;
    logic [2:0] exp_x = 3'd0;
    int         exp_err8 = 0;
    int         exp_err2 = 0;

    always #5 clk = ~clk;

    zad1_rx_decoder #(.ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .ser_in(ser_in), .err_clr(err_clr),
        .x_out(x_out), .x_valid(x_valid), .code_err(code_err), .frame_err(frame_err),
        .busy(busy), .err_cnt(err_cnt)
    );

    zad1_rx_decoder #(.ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .ser_in(ser_in), .err_clr(err_clr),
        .x_out(x_out2), .x_valid(x_valid2), .code_err(code_err2), .frame_err(frame_err2),
        .busy(busy2), .err_cnt(err_cnt2)
    );

    function automatic logic legal_of(input logic [5:0] w, output logic [2:0] x);
        legal_of = 1'b1;
        x = 3'd0;
        case (w)
            6'h3E: x = 3'd0;
            6'h3D: x = 3'd1;
            6'h3B: x = 3'd2;
            6'h37: x = 3'd3;
            6'h2F: x = 3'd4;
            6'h1F: x = 3'd5;
            6'h2B: x = 3'd6;
            6'h17: x = 3'd7;
            default: legal_of = 1'b0;
        endcase
    endfunction

    // output monitor: each result pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && (x_valid || code_err || frame_err)) begin
            ev_t e;
            logic [1:0] k;
            k = x_valid ? 2'(K_VALID) : (code_err ? 2'(K_CODE) : 2'(K_FRAME));
            n_checks++;
            if (int'(x_valid) + int'(code_err) + int'(frame_err) != 1) begin
                $display("FAIL pulse_onehot: got valid=%b code=%b frame=%b, need exactly one",
                         x_valid, code_err, frame_err);
            end else if (sb.size() == 0) begin
                $display("FAIL unexpected_pulse: got kind=%0d x_out=%0d, need no pulse", k, x_out);
            end else begin
                e = sb.pop_front();
                if (k !== e.kind || x_out !== e.x)
                    $display("FAIL result: got kind=%0d x_out=%0d, need kind=%0d x_out=%0d",
                             k, x_out, e.kind, e.x);
                else
                    n_pass++;
            end
            if (x_valid) valid_seen++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, need finish");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

    task automatic drive_bit(input logic b, input int gap);
        ser_in = b;
        bit_en = 1'b1;
        @(posedge clk); #1;
        bit_en  = 1'b0;
        err_clr = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [5:0] w, input logic stop, input int gap,
                              input logic clr_at_stop);
        logic [2:0] x;
        logic       ok;
        ev_t        e;
        drive_bit(1'b0, gap);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL busy_start: got %b, need 1", busy);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            drive_bit(w[i], gap);
            n_checks++;
            if (busy !== 1'b1) $display("FAIL busy_data: got %b, need 1", busy);
            else n_pass++;
        end
        ok = legal_of(w, x);
        if (stop && ok) begin
            exp_x = x;
            e = '{kind: 2'(K_VALID), x: x};
        end else begin
            e = '{kind: (stop ? 2'(K_CODE) : 2'(K_FRAME)), x: exp_x};
            if (clr_at_stop) begin
                exp_err8 = 1;
                exp_err2 = 1;
            end else begin
                if (exp_err8 < 255) exp_err8++;
                if (exp_err2 < 3) exp_err2++;
            end
        end
        sb.push_back(e);
        err_clr = clr_at_stop;
        drive_bit(stop, gap);
        n_checks++;
        if (busy !== !stop) $display("FAIL busy_stop: got %b, need %b", busy, !stop);
        else n_pass++;
    endtask

    task automatic check_errs(input string tag);
        n_checks++;
        if (err_cnt !== 8'(exp_err8))
            $display("FAIL err_cnt_%s: got %0d, need %0d", tag, err_cnt, exp_err8);
        else n_pass++;
        n_checks++;
        if (err_cnt2 !== 2'(exp_err2))
            $display("FAIL err_cnt2_%s: got %0d, need %0d", tag, err_cnt2, exp_err2);
        else n_pass++;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        exp_err8 = 0;
        exp_err2 = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bit_en = 1'b0; ser_in = 1'b1; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({x_out, x_valid, code_err, frame_err, busy} !== 7'd0)
            $display("FAIL reset_outputs: got x=%0d v=%b c=%b f=%b busy=%b, need all 0",
                     x_out, x_valid, code_err, frame_err, busy);
        else n_pass++;
        check_errs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_latency();
        send_frame(6'h1F, 1'b1, 0, 1'b0);
        n_checks++;
        if (x_valid !== 1'b1 || x_out !== 3'd5)
            $display("FAIL latency_x5: got valid=%b x_out=%0d, need valid=1 x_out=5", x_valid, x_out);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (x_valid !== 1'b0) $display("FAIL valid_one_cycle: got %b, need 0", x_valid);
        else n_pass++;
        check_errs("single");
    endtask

    task automatic test_back_to_back();
        logic [5:0] cw [8] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h2B, 6'h17};
        int v0;
        v0 = valid_seen;
        for (int i = 0; i < 8; i++) send_frame(cw[i], 1'b1, 2, 1'b0);
        @(posedge clk); #1;
        n_checks++;
        if (valid_seen - v0 != 8) $display("FAIL b2b_valid_count: got %0d, need 8", valid_seen - v0);
        else n_pass++;
        n_checks++;
        if (x_out !== 3'd7) $display("FAIL b2b_last_x: got %0d, need 7", x_out);
        else n_pass++;
    endtask

    task automatic test_code_err();
        pulse_clr();
        send_frame(6'h3B, 1'b1, 1, 1'b0);
        send_frame(6'h3F, 1'b1, 1, 1'b0);
        @(posedge clk); #1;
        n_checks++;
        if (x_out !== 3'd2) $display("FAIL code_err_hold_x: got %0d, need 2", x_out);
        else n_pass++;
        check_errs("code");
    endtask

    task automatic test_frame_err();
        pulse_clr();
        send_frame(6'h3E, 1'b0, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_bit(1'b0, 1);
            n_checks++;
            if (busy !== 1'b1) $display("FAIL wait_idle_busy: got %b, need 1", busy);
            else n_pass++;
        end
        drive_bit(1'b1, 1);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL wait_idle_exit: got %b, need 0", busy);
        else n_pass++;
        send_frame(6'h17, 1'b1, 1, 1'b0);
        @(posedge clk); #1;
        n_checks++;
        if (x_out !== 3'd7) $display("FAIL frame_then_x7: got %0d, need 7", x_out);
        else n_pass++;
        check_errs("frame");
    endtask

    task automatic test_saturation();
        pulse_clr();
        for (int i = 0; i < 5; i++) send_frame(6'h00, 1'b1, 0, 1'b0);
        @(posedge clk); #1;
        check_errs("sat");
        send_frame(6'h3F, 1'b1, 0, 1'b1);
        @(posedge clk); #1;
        check_errs("clr_and_err");
    endtask

    task automatic test_reset_midframe();
        drive_bit(1'b0, 0);
        drive_bit(1'b1, 0);
        drive_bit(1'b1, 0);
        drive_bit(1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        exp_x = 3'd0; exp_err8 = 0; exp_err2 = 0;
        n_checks++;
        if ({x_out, x_valid, code_err, frame_err, busy} !== 7'd0)
            $display("FAIL midframe_reset_outputs: got x=%0d v=%b c=%b f=%b busy=%b, need all 0",
                     x_out, x_valid, code_err, frame_err, busy);
        else n_pass++;
        check_errs("midreset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ser_in = 1'b1;
        @(posedge clk); #1;
        send_frame(6'h2B, 1'b1, 1, 1'b0);
        @(posedge clk); #1;
        n_checks++;
        if (x_out !== 3'd6) $display("FAIL post_reset_x6: got %0d, need 6", x_out);
        else n_pass++;
        check_errs("postreset");
    endtask

    initial begin
        test_reset();
        test_single_latency();
        test_back_to_back();
        test_code_err();
        test_frame_err();
        test_saturation();
        test_reset_midframe();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) $display("FAIL pending_results: got %0d outstanding, need 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
